usb_tx_encoder: RTL and testbench

Serial transmit stage directly downstream of the protocol block. Accepts one 99-bit packet per handshake, adds CRC (token: CRC5, data: CRC16), performs bit stuffing and NRZI encoding, drives the differential D+/D- pair one bit per clk, and ends each packet with an EOP. It pulses `pkt_sent` when the packet has fully left the wire; the protocol FSMs use that pulse to advance.

---
 rtl/usb_tx_encoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder
//   Serial USB transmit stage. Captures one 99-bit packet per handshake,
//   appends CRC5 (token) or CRC16 (data), bit-stuffs, NRZI-encodes and drives
//   the differential pair one bit per clock, finishing with SE0 SE0 J.
//
// Ports
//   clk           bit clock, one line bit per cycle
//   rst_b         asynchronous active-low reset
//   pkt_in        [98:91] SYNC, [90:83] PID, token [82:76] ADDR / [75:72] ENDP,
//                 data [82:19] payload
//   pkt_in_avail  packet valid, sampled only while idle
//   dp, dm        registered D+ / D- line levels
//   tx_en         registered, high from the first SYNC bit through the SE0 cycles
//   pkt_sent      registered one-cycle pulse on the closing J of the EOP
//   busy          high whenever the encoder is not idle
module usb_tx_encoder (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [98:0] pkt_in,
    input  logic        pkt_in_avail,
    output logic        dp,
    output logic        dm,
    output logic        tx_en,
    output logic        pkt_sent,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        BODY,
        CRC,
        EOP_SE0_1,
        EOP_SE0_2,
        EOP_J
    } state_t;

    state_t      state, state_nxt;
    logic [6:0]  bit_cnt, bit_cnt_nxt;
    logic [2:0]  ones_cnt, ones_cnt_nxt;
    logic        lvl, lvl_nxt;
    logic        dp_nxt, dm_nxt, tx_en_nxt, pkt_sent_nxt;

    logic [98:0] pkt_q;
    logic [4:0]  crc5_q;
    logic [15:0] crc16_q;

    logic        capture;
    logic        drive_bit;
    logic        raw_bit;
    logic        crc_upd;
    logic        is_tok;
    logic        has_body;
    logic [6:0]  cur_len;
    state_t      nxt_field;

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = c[4] ^ b;
        return {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    // Raw bit idx of field f. Fields go out LSB-first, the CRC MSB-first and
    // inverted. Token body is ADDR then ENDP, which sit in descending order
    // in the packet word, hence the two-range mapping.
    function automatic logic field_bit(input state_t f, input logic [6:0] idx,
                                       input logic [98:0] p, input logic tok,
                                       input logic [4:0] c5, input logic [15:0] c16);
        logic [6:0] pos;
        logic       b;
        pos = 7'd0;
        case (f)
            SYNC:    pos = 7'd91 + idx;
            PID:     pos = 7'd83 + idx;
            BODY: begin
                if (tok)
                    pos = (idx < 7'd7) ? (7'd76 + idx) : (7'd65 + idx);
                else
                    pos = 7'd19 + idx;
            end
            default: pos = 7'd0;
        endcase
        if (f == CRC)
            b = tok ? ~c5[3'd4 - idx[2:0]] : ~c16[4'd15 - idx[3:0]];
        else
            b = p[pos];
        return b;
    endfunction

    assign is_tok   = (pkt_q[84:83] == 2'b01);
    assign has_body = pkt_q[83];          // PID[1:0] of 01 or 11
    assign busy     = (state != IDLE);

    always_comb begin
        cur_len   = 7'd8;
        nxt_field = IDLE;
        case (state)
            SYNC: begin
                cur_len   = 7'd8;
                nxt_field = PID;
            end
            PID: begin
                cur_len   = 7'd8;
                nxt_field = has_body ? BODY : EOP_SE0_1;
            end
            BODY: begin
                cur_len   = is_tok ? 7'd11 : 7'd64;
                nxt_field = CRC;
            end
            CRC: begin
                cur_len   = is_tok ? 7'd5 : 7'd16;
                nxt_field = EOP_SE0_1;
            end
            default: begin
                cur_len   = 7'd8;
                nxt_field = IDLE;
            end
        endcase
    end

    // The state names the field whose bit is on the wire this cycle; bit_cnt
    // counts the field bits already sent, so each edge emits the next bit.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        ones_cnt_nxt = ones_cnt;
        lvl_nxt      = lvl;
        capture      = 1'b0;
        drive_bit    = 1'b0;
        raw_bit      = 1'b0;
        crc_upd      = 1'b0;

        case (state)
            IDLE: begin
                if (pkt_in_avail) begin
                    // First SYNC bit comes straight from the input so it is on
                    // the line in the cycle right after capture.
                    capture     = 1'b1;
                    state_nxt   = SYNC;
                    drive_bit   = 1'b1;
                    raw_bit     = pkt_in[91];
                    bit_cnt_nxt = 7'd1;
                end
            end
            SYNC, PID, BODY, CRC: begin
                if (ones_cnt == 3'd6) begin
                    // Stuff bit: source stream stalls, counters hold.
                    drive_bit = 1'b1;
                    raw_bit   = 1'b0;
                end else if (bit_cnt != cur_len) begin
                    drive_bit   = 1'b1;
                    raw_bit     = field_bit(state, bit_cnt, pkt_q, is_tok, crc5_q, crc16_q);
                    bit_cnt_nxt = bit_cnt + 7'd1;
                    crc_upd     = (state == BODY);
                end else begin
                    state_nxt = nxt_field;
                    if (nxt_field == EOP_SE0_1) begin
                        bit_cnt_nxt  = 7'd0;
                        ones_cnt_nxt = 3'd0;
                    end else begin
                        drive_bit   = 1'b1;
                        raw_bit     = field_bit(nxt_field, 7'd0, pkt_q, is_tok, crc5_q, crc16_q);
                        bit_cnt_nxt = 7'd1;
                        crc_upd     = (nxt_field == BODY);
                    end
                end
            end
            EOP_SE0_1: state_nxt = EOP_SE0_2;
            EOP_SE0_2: begin
                state_nxt = EOP_J;
                lvl_nxt   = 1'b1;     // next packet's NRZI starts from J
            end
            EOP_J:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase

        if (drive_bit) begin
            lvl_nxt      = raw_bit ? lvl : ~lvl;
            ones_cnt_nxt = raw_bit ? (ones_cnt + 3'd1) : 3'd0;
        end

        dp_nxt       = 1'b1;
        dm_nxt       = 1'b0;
        tx_en_nxt    = 1'b0;
        pkt_sent_nxt = 1'b0;
        case (state_nxt)
            SYNC, PID, BODY, CRC: begin
                dp_nxt    = lvl_nxt;
                dm_nxt    = ~lvl_nxt;
                tx_en_nxt = 1'b1;
            end
            EOP_SE0_1, EOP_SE0_2: begin
                dp_nxt    = 1'b0;
                dm_nxt    = 1'b0;
                tx_en_nxt = 1'b1;
            end
            EOP_J:   pkt_sent_nxt = 1'b1;
            default: pkt_sent_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            bit_cnt  <= 7'd0;
            ones_cnt <= 3'd0;
            lvl      <= 1'b1;
            dp       <= 1'b1;
            dm       <= 1'b0;
            tx_en    <= 1'b0;
            pkt_sent <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            ones_cnt <= ones_cnt_nxt;
            lvl      <= lvl_nxt;
            dp       <= dp_nxt;
            dm       <= dm_nxt;
            tx_en    <= tx_en_nxt;
            pkt_sent <= pkt_sent_nxt;
        end
    end

    // Packet shadow and CRC accumulators; always reinitialised on capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            pkt_q   <= pkt_in;
            crc5_q  <= 5'h1F;
            crc16_q <= 16'hFFFF;
        end else if (crc_upd) begin
            crc5_q  <= crc5_step(crc5_q, raw_bit);
            crc16_q <= crc16_step(crc16_q, raw_bit);
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Testbench for usb_tx_encoder: stimulus pushes the expected line-symbol
// string of each packet into a scoreboard; a monitor on the falling edge
// assembles what the DUT drives and compares whole packets.
// Symbols: J, K, 0 = SE0 with tx_en, P = closing J with pkt_sent, X = illegal.
module tb_usb_tx_encoder;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [98:0] pkt_in = '0;
    logic        pkt_in_avail = 1'b0;
    logic        dp, dm, tx_en, pkt_sent, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    string exp_sym[$];
    int    exp_cap[$];
    string exp_name[$];

    string cur = "";
    bit    in_pkt = 1'b0;
    int    first_cyc = 0;

    usb_tx_encoder dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .pkt_in       (pkt_in),
        .pkt_in_avail (pkt_in_avail),
        .dp           (dp),
        .dm           (dm),
        .tx_en        (tx_en),
        .pkt_sent     (pkt_sent),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    // Reference: raw stream, CRC, stuffing and NRZI built independently.
    function automatic string model(input logic [98:0] p);
        bit          raw[$];
        bit          body[$];
        logic [4:0]  c5;
        logic [15:0] c16;
        bit          fb;
        bit          lvl;
        int          ones;
        string       s;
        for (int i = 0; i < 8; i++) raw.push_back(p[91+i]);
        for (int i = 0; i < 8; i++) raw.push_back(p[83+i]);
        if (p[84:83] == 2'b01) begin
            for (int i = 0; i < 7; i++) body.push_back(p[76+i]);
            for (int i = 0; i < 4; i++) body.push_back(p[72+i]);
        end else if (p[84:83] == 2'b11) begin
            for (int i = 0; i < 64; i++) body.push_back(p[19+i]);
        end
        c5  = 5'h1F;
        c16 = 16'hFFFF;
        foreach (body[i]) begin
            raw.push_back(body[i]);
            fb  = body[i] ^ c5[4];
            c5  = {c5[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b0);
            fb  = body[i] ^ c16[15];
            c16 = {c16[14:0], 1'b0} ^ (fb ? 16'b1000_0000_0000_0101 : 16'b0);
        end
        if (p[84:83] == 2'b01)
            for (int k = 4; k >= 0; k--) raw.push_back(~c5[k]);
        else if (p[84:83] == 2'b11)
            for (int k = 15; k >= 0; k--) raw.push_back(~c16[k]);
        lvl  = 1'b1;
        ones = 0;
        s    = "";
        foreach (raw[i]) begin
            if (!raw[i]) lvl = ~lvl;
            s    = {s, lvl ? "J" : "K"};
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl  = ~lvl;
                s    = {s, lvl ? "J" : "K"};
                ones = 0;
            end
        end
        return {s, "00P"};
    endfunction

    function automatic string sym_char();
        if (tx_en && !pkt_sent) begin
            if (dp && !dm)  return "J";
            if (!dp && dm)  return "K";
            if (!dp && !dm) return "0";
            return "X";
        end
        if (pkt_sent && !tx_en && dp && !dm) return "P";
        return "X";
    endfunction

    // Monitor
    always @(negedge clk) begin
        string e, n;
        int    c;
        if (!rst_b) begin
            cur    = "";
            in_pkt = 1'b0;
        end else if (tx_en || pkt_sent) begin
            if (!in_pkt) begin
                in_pkt    = 1'b1;
                cur       = "";
                first_cyc = cyc;
            end
            cur = {cur, sym_char()};
            if (pkt_sent || cur.len() > 200) begin
                in_pkt = 1'b0;
                if (exp_sym.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pkt got=%s", cur);
                end else begin
                    e = exp_sym.pop_front();
                    c = exp_cap.pop_front();
                    n = exp_name.pop_front();
                    total++;
                    if (cur != e) begin
                        bad++;
                        $display("FAIL %s_line got=%s exp=%s", n, cur, e);
                    end
                    check({n, "_start_cyc"}, first_cyc, c);
                    check({n, "_len"}, cur.len(), e.len());
                end
            end
        end else begin
            check("idle_line", {dp, dm}, 2'b10);
        end
    end

    task automatic wait_idle(input string name, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_done_in_time"}, (i < limit), 1);
        check({name, "_sb_drained"}, exp_sym.size(), 0);
    endtask

    task automatic send(input string name, input logic [98:0] p, input string expv);
        @(negedge clk);
        pkt_in       = p;
        pkt_in_avail = 1'b1;
        @(posedge clk);
        #1;
        exp_sym.push_back(expv);
        exp_cap.push_back(cyc);
        exp_name.push_back(name);
        pkt_in_avail = 1'b0;
        check({name, "_busy"}, busy, 1);
        wait_idle(name, 300);
    endtask

    localparam string ACK_S = {"KJKJKJKK", "JJKJJKKK", "00P"};
    localparam string TOK_S = {"KJKJKJKK", "KJKKJJJK", "KJJKKJK", "JJJJ", "JKKKK", "00P"};

    initial begin
        logic [98:0] ack, tok, nak, pre, d_ones, d_mix, d_zero;
        int c1;
        ack    = {8'h80, 8'hD2, 83'h0};
        tok    = {8'h80, 8'h69, 7'h15, 4'hE, 72'h0};
        nak    = {8'h80, 8'h5A, 83'h0};
        pre    = {8'h80, 8'h3C, 83'h0};
        d_ones = {8'h80, 8'hC3, 64'hFFFF_FFFF_FFFF_FFFF, 19'h0};
        d_mix  = {8'h80, 8'h4B, 64'h0123_4567_89AB_CDEF, 19'h5A5A5};
        d_zero = {8'h80, 8'hC3, 64'h0, 19'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dp", dp, 1);
        check("rst_dm", dm, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_sent", pkt_sent, 0);
        rst_b = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_tx_en", tx_en, 0);

        send("ack", ack, ACK_S);
        send("token", tok, TOK_S);
        send("nak", nak, model(nak));
        send("pre", pre, model(pre));
        send("data_ones", d_ones, model(d_ones));
        send("data_mix", d_mix, model(d_mix));
        send("data_zero", d_zero, model(d_zero));

        // Abort mid data packet at cycle E+40
        @(negedge clk);
        pkt_in       = d_mix;
        pkt_in_avail = 1'b1;
        @(posedge clk);
        #1;
        pkt_in_avail = 1'b0;
        repeat (39) @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        check("abort_dp", dp, 1);
        check("abort_dm", dm, 0);
        check("abort_tx_en", tx_en, 0);
        check("abort_busy", busy, 0);
        check("abort_pkt_sent", pkt_sent, 0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        send("ack_after_abort", ack, ACK_S);

        // Back-to-back with pkt_in changed mid-packet
        @(negedge clk);
        pkt_in       = ack;
        pkt_in_avail = 1'b1;
        @(posedge clk);
        #1;
        c1 = cyc;
        exp_sym.push_back(ACK_S);
        exp_cap.push_back(c1);
        exp_name.push_back("b2b_first");
        repeat (5) @(posedge clk);
        #1;
        pkt_in = tok;
        exp_sym.push_back(TOK_S);
        exp_cap.push_back(c1 + 20);
        exp_name.push_back("b2b_second");
        repeat (15) @(posedge clk);
        #1;
        pkt_in_avail = 1'b0;
        check("b2b_second_busy", busy, 1);
        wait_idle("b2b", 300);

        repeat (3) @(negedge clk);
        check("end_in_pkt", in_pkt, 0);
        check("end_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
